// File: rtl/sobel_window_gradient.sv
// Sobel 3x3 window over incoming 3-row columns; emits |Gx|+|Gy| per complete window.
// Latency 2 clocks from window load, no backpressure; SOBEL_THRESHOLD_EN selects binary output.
module sobel_window_gradient #(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_WIDTH  = 256,
   parameter int IMG_HEIGHT = 256
) (
   input  logic                  CLK,
   input  logic                  RST_n,
   input  logic                  Enable,
   input  logic [DATA_WIDTH-1:0] DataIn0,
   input  logic [DATA_WIDTH-1:0] DataIn1,
   input  logic [DATA_WIDTH-1:0] DataIn2,
`ifdef SOBEL_THRESHOLD_EN
   input  logic [7:0]            Threshold,
`endif
   output logic [7:0]            DataOut,
   output logic                  ValidOut,
   output logic                  FrameDone
);

   localparam int GW = DATA_WIDTH + 3;
   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);

   logic [DATA_WIDTH-1:0] col_in [3];
   logic [DATA_WIDTH-1:0] win_q  [3][3];
   logic [CW-1:0]         col_cnt_q, col_cnt_d;
   logic [RW-1:0]         row_cnt_q, row_cnt_d;
   logic                  win_vld_q, win_vld_d, win_eof_q, win_eof_d;
   logic                  last_col, last_row;
   logic signed [GW-1:0]  gx_q, gx_d, gy_q, gy_d;
   logic                  s1_vld_q, s1_eof_q;
   logic [GW-1:0]         abs_x, abs_y, mag;
   logic [7:0]            dout_d;

   assign col_in[0] = DataIn0;
   assign col_in[1] = DataIn1;
   assign col_in[2] = DataIn2;

   function automatic logic signed [GW-1:0] px(input logic [DATA_WIDTH-1:0] v);
      return $signed({3'b000, v});
   endfunction

   // Tags are judged on the column being accepted, before the counters advance.
   always_comb begin
      last_col  = (col_cnt_q == CW'(IMG_WIDTH - 1));
      last_row  = (row_cnt_q == RW'(IMG_HEIGHT - 1));
      col_cnt_d = col_cnt_q;
      row_cnt_d = row_cnt_q;
      win_vld_d = 1'b0;
      win_eof_d = 1'b0;
      if (Enable) begin
         win_vld_d = (col_cnt_q >= CW'(2)) && (row_cnt_q >= RW'(2));
         win_eof_d = last_col && last_row;
         if (last_col) begin
            col_cnt_d = '0;
            row_cnt_d = last_row ? '0 : row_cnt_q + RW'(1);
         end else begin
            col_cnt_d = col_cnt_q + CW'(1);
         end
      end
   end

   always_comb begin
      gx_d = (px(win_q[0][2]) + (px(win_q[1][2]) <<< 1) + px(win_q[2][2]))
           - (px(win_q[0][0]) + (px(win_q[1][0]) <<< 1) + px(win_q[2][0]));
      gy_d = (px(win_q[2][0]) + (px(win_q[2][1]) <<< 1) + px(win_q[2][2]))
           - (px(win_q[0][0]) + (px(win_q[0][1]) <<< 1) + px(win_q[0][2]));
   end

   always_comb begin
      abs_x = gx_q[GW-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
      abs_y = gy_q[GW-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
      mag   = abs_x + abs_y;
`ifdef SOBEL_THRESHOLD_EN
      dout_d = (mag >= GW'(Threshold)) ? 8'hFF : 8'h00;
`else
      dout_d = (mag > GW'(255)) ? 8'hFF : mag[7:0];
`endif
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               win_q[r][c] <= '0;
         col_cnt_q <= '0;
         row_cnt_q <= '0;
         win_vld_q <= 1'b0;
         win_eof_q <= 1'b0;
         gx_q      <= '0;
         gy_q      <= '0;
         s1_vld_q  <= 1'b0;
         s1_eof_q  <= 1'b0;
         DataOut   <= 8'h00;
         ValidOut  <= 1'b0;
         FrameDone <= 1'b0;
      end else begin
         col_cnt_q <= col_cnt_d;
         row_cnt_q <= row_cnt_d;
         win_vld_q <= win_vld_d;
         win_eof_q <= win_eof_d;
         if (Enable) begin
            for (int r = 0; r < 3; r++) begin
               win_q[r][0] <= win_q[r][1];
               win_q[r][1] <= win_q[r][2];
               win_q[r][2] <= col_in[r];
            end
         end
         // Pipeline free-runs; only the valid tag decides what reaches the output.
         gx_q      <= gx_d;
         gy_q      <= gy_d;
         s1_vld_q  <= win_vld_q;
         s1_eof_q  <= win_eof_q;
         ValidOut  <= s1_vld_q;
         FrameDone <= s1_vld_q && s1_eof_q;
         if (s1_vld_q)
            DataOut <= dout_d;
      end
   end

endmodule

// File: tb/tb_sobel_window_gradient.sv
// Directed bench for sobel_window_gradient (8x6 frames); scoreboard of expected pixels with due cycle.
module tb_sobel_window_gradient;

   localparam int W = 8;
   localparam int H = 6;

   logic       CLK = 1'b0;
   logic       RST_n = 1'b0;
   logic       Enable = 1'b0;
   logic [7:0] DataIn0 = '0, DataIn1 = '0, DataIn2 = '0;
   logic [7:0] DataOut;
   logic       ValidOut, FrameDone;
`ifdef SOBEL_THRESHOLD_EN
   logic [7:0] Threshold = 8'd50;
`endif

   always #5 CLK = ~CLK;

   sobel_window_gradient #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .CLK(CLK), .RST_n(RST_n), .Enable(Enable),
      .DataIn0(DataIn0), .DataIn1(DataIn1), .DataIn2(DataIn2),
`ifdef SOBEL_THRESHOLD_EN
      .Threshold(Threshold),
`endif
      .DataOut(DataOut), .ValidOut(ValidOut), .FrameDone(FrameDone)
   );

   typedef struct packed {
      logic [7:0]  data;
      logic        fd;
      logic [31:0] due;
   } exp_t;

   exp_t       sb[$];
   int         errors = 0, checks = 0;
   int         cyc = 0, n_vld = 0, n_fd = 0;
   logic [7:0] last_out = 8'h00;
   // Row i of img is image row i-2: rows 0/1 are what the line buffer feeds above the frame.
   int         img [H+2][W];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic logic [7:0] model(input int r, input int c);
      int p [3][3];
      int gx, gy, mag;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            p[i][j] = img[r+i][c-2+j];
      gx  = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
      gy  = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
      mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_THRESHOLD_EN
      return (mag >= int'(Threshold)) ? 8'hFF : 8'h00;
`else
      return (mag > 255) ? 8'hFF : 8'(mag);
`endif
   endfunction

   task automatic fill(input int mode);
      for (int i = 0; i < H + 2; i++)
         for (int j = 0; j < W; j++)
            case (mode)
               0:       img[i][j] = 128;
               1:       img[i][j] = (j >= 4) ? 255 : 0;
               2:       img[i][j] = (i == 4 && j == 3) ? 10 : 0;
               3:       img[i][j] = int'($urandom_range(0, 255));
               default: img[i][j] = (j >= 4) ? 30 : 0;
            endcase
   endtask

   task automatic observe();
      exp_t e;
      if (ValidOut) begin
         n_vld++;
         if (FrameDone) n_fd++;
         if (sb.size() == 0) begin
            chk("spurious_valid", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("data", 32'(DataOut), 32'(e.data));
            chk("framedone", 32'(FrameDone), 32'(e.fd));
            chk("latency_cycle", 32'(cyc), e.due);
         end
         last_out = DataOut;
      end else begin
         chk("fd_without_valid", 32'(FrameDone), 32'd0);
         chk("dout_hold", 32'(DataOut), 32'(last_out));
         if (sb.size() > 0 && sb[0].due <= 32'(cyc)) begin
            chk("missing_valid", 32'd0, 32'd1);
            void'(sb.pop_front());
         end
      end
   endtask

   task automatic step(input bit en, input int r, input int c);
      exp_t e;
      Enable = en;
      if (en) begin
         DataIn0 = 8'(img[r][c]);
         DataIn1 = 8'(img[r+1][c]);
         DataIn2 = 8'(img[r+2][c]);
         if (r >= 2 && c >= 2) begin
            e.data = model(r, c);
            e.fd   = (r == H-1 && c == W-1);
            e.due  = 32'(cyc + 3);
            sb.push_back(e);
         end
      end else begin
         DataIn0 = 8'($urandom);
         DataIn1 = 8'($urandom);
         DataIn2 = 8'($urandom);
      end
      @(posedge CLK);
      cyc++;
      #1;
      observe();
   endtask

   task automatic run_frame(input bit gap, input int npix);
      int k = 0;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            if (k == npix) return;
            step(1'b1, r, c);
            k++;
            if (gap) step(1'b0, 0, 0);
         end
   endtask

   task automatic full_frame(input string tag, input int mode, input bit gap);
      fill(mode);
      n_vld = 0;
      n_fd  = 0;
      run_frame(gap, W*H);
      repeat (4) step(1'b0, 0, 0);
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
      chk({tag, "_valid_count"}, 32'(n_vld), 32'((W-2)*(H-2)));
      chk({tag, "_framedone_count"}, 32'(n_fd), 32'd1);
   endtask

   initial begin
      repeat (2) @(posedge CLK);
      #1;
      chk("reset_dataout", 32'(DataOut), 32'd0);
      chk("reset_validout", 32'(ValidOut), 32'd0);
      chk("reset_framedone", 32'(FrameDone), 32'd0);
      RST_n = 1'b1;

      full_frame("flat", 0, 1'b0);
      full_frame("vstep", 1, 1'b0);
      full_frame("single_px", 2, 1'b0);
      full_frame("random", 3, 1'b0);
      full_frame("flat_gap", 0, 1'b1);
      full_frame("vstep_gap", 1, 1'b1);
      full_frame("random_gap", 3, 1'b1);

      // Reset in the middle of line 3 with windows in flight.
      fill(3);
      run_frame(1'b0, 3*W + 4);
      #2 RST_n = 1'b0;
      #1;
      chk("midreset_dataout", 32'(DataOut), 32'd0);
      chk("midreset_validout", 32'(ValidOut), 32'd0);
      chk("midreset_framedone", 32'(FrameDone), 32'd0);
      sb.delete();
      last_out = 8'h00;
      Enable   = 1'b0;
      repeat (2) begin
         @(posedge CLK);
         cyc++;
      end
      #1 RST_n = 1'b1;
      full_frame("after_reset", 3, 1'b0);

`ifdef SOBEL_THRESHOLD_EN
      Threshold = 8'd100;
      full_frame("thr100", 4, 1'b0);
      Threshold = 8'd121;
      full_frame("thr121", 4, 1'b0);
`else
      full_frame("step30", 4, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
